serial_subtractor: RTL



---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 103 ++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The slave modport is the subtractor side; the master drives requests.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             borrow_in_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_out_o;

  modport master (
    output start_i, a_i, b_i, borrow_in_i,
    input  busy_o, done_o, diff_o, borrow_out_o
  );

  modport slave (
    input  start_i, a_i, b_i, borrow_in_i,
    output busy_o, done_o, diff_o, borrow_out_o
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: DIFF = A - B - borrow_in over WIDTH cycles,
// one full-subtractor cell plus a borrow flip-flop, start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  serial_subtractor_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrowOut_q, borrowOut_d;

  logic             diffBit;
  logic             borrowNext;
  logic [WIDTH-1:0] partialNext;

  // Full-subtractor cell on the current LSBs.
  assign diffBit     = aShift_q[0] ^ bShift_q[0] ^ borrow_q;
  assign borrowNext  = (~aShift_q[0] & bShift_q[0]) |
                       (~(aShift_q[0] ^ bShift_q[0]) & borrow_q);
  assign partialNext = {diffBit, partial_q[WIDTH-1:1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      aShift_q    <= '0;
      bShift_q    <= '0;
      partial_q   <= '0;
      count_q     <= '0;
      borrow_q    <= 1'b0;
      diff_q      <= '0;
      borrowOut_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aShift_q    <= aShift_d;
      bShift_q    <= bShift_d;
      partial_q   <= partial_d;
      count_q     <= count_d;
      borrow_q    <= borrow_d;
      diff_q      <= diff_d;
      borrowOut_q <= borrowOut_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    aShift_d    = aShift_q;
    bShift_d    = bShift_q;
    partial_d   = partial_q;
    count_d     = count_q;
    borrow_d    = borrow_q;
    diff_d      = diff_q;
    borrowOut_d = borrowOut_q;

    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start directly so back-to-back runs have no gap.
        if (bus.start_i) begin
          aShift_d = bus.a_i;
          bShift_d = bus.b_i;
          borrow_d = bus.borrow_in_i;
          count_d  = '0;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        aShift_d  = aShift_q >> 1;
        bShift_d  = bShift_q >> 1;
        partial_d = partialNext;
        borrow_d  = borrowNext;
        count_d   = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          diff_d      = partialNext;
          borrowOut_d = borrowNext;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o       = (state_q == SHIFT);
  assign bus.done_o       = (state_q == DONE);
  assign bus.diff_o       = diff_q;
  assign bus.borrow_out_o = borrowOut_q;
endmodule
